// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin packet scheduler sharing one UART TX channel
// Sources hand 16-bit packets over valid/ready; packets queue in a FIFO and launch one at a time with an enforced idle gap.
module uart_tx_scheduler #(
  parameter int NUM_REQ     = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int GAP_CYCLES  = 32,
  parameter int BUSY_WAIT   = 8,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            flush,
  input  logic                            tx_busy,
  output logic                            tx_data_valid,
  output logic [DATA_WIDTH-1:0]           tx_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            stall_err
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW   = $clog2(STALL_LIMIT + 1);
  localparam int TMAX = (BUSY_WAIT > GAP_CYCLES) ? BUSY_WAIT : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_REQ  = PW'(NUM_REQ - 1);
  localparam logic [SW-1:0] STALL_C   = SW'(STALL_LIMIT);
  localparam logic [TW-1:0] BUSY_END  = TW'(BUSY_WAIT - 1);
  localparam logic [TW-1:0] GAP_END   = TW'(GAP_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LAUNCH    = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [PW-1:0]         rr_ptr, grant_idx, cand;
  logic                  grant_any;
  logic                  pop;
  logic [2:0]            state;
  logic [TW-1:0]         timer;
  logic [SW-1:0]         stall_cnt [NUM_REQ];

  // Grant is withheld whenever full, even if the head pops this cycle.
  always_comb begin
    req_ready = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (fifo_count < DEPTH_C && !flush) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = PW'((int'(rr_ptr) + k) % NUM_REQ);
        if (!grant_any && req_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
    req_ready[grant_idx] = grant_any;
  end

  // A flush racing the launch decision can leave LAUNCH with nothing to pop.
  assign pop = (state == S_LAUNCH) && (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (grant_any) mem[wr_ptr] <= req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rr_ptr     <= '0;
    end else begin
      if (grant_any) rr_ptr <= (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (grant_any) wr_ptr <= wr_ptr + 1'b1;
        if (pop)       rd_ptr <= rd_ptr + 1'b1;
        if (grant_any && !pop)      fifo_count <= fifo_count + 1'b1;
        else if (!grant_any && pop) fifo_count <= fifo_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_err <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) stall_cnt[i] <= '0;
    end else if (flush) begin
      stall_err <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) stall_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && !req_ready[i]) begin
          if (stall_cnt[i] != STALL_C) stall_cnt[i] <= stall_cnt[i] + 1'b1;
          if (stall_cnt[i] == STALL_C - 1'b1) stall_err <= 1'b1;
        end else begin
          stall_cnt[i] <= '0;
        end
      end
    end
  end

  // Busy periods seen in IDLE were not caused by us, so no gap follows them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      timer         <= '0;
      tx_data_valid <= 1'b0;
      tx_data       <= '0;
    end else begin
      tx_data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fifo_count != '0 && !tx_busy) begin
            state         <= S_LAUNCH;
            tx_data_valid <= 1'b1;
            tx_data       <= mem[rd_ptr];
          end
        end
        S_LAUNCH: begin
          state <= S_WAIT_BUSY;
          timer <= '0;
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= S_WAIT_DONE;
          end else if (timer == BUSY_END) begin
            state <= S_GAP;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            state <= S_GAP;
            timer <= '0;
          end
        end
        S_GAP: begin
          if (timer == GAP_END) state <= S_IDLE;
          else                  timer <= timer + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
// Queue-based reference model scores every cycle; scenario tasks add targeted checks.
module tb_uart_tx_scheduler;

  localparam int NUM_REQ = 3;
  localparam int DW      = 16;
  localparam int DEPTH   = 4;
  localparam int GAP     = 32;
  localparam int BWAIT   = 8;
  localparam int SLIM    = 1024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req_valid;
  logic [47:0] req_data;
  logic [2:0]  req_ready;
  logic        flush;
  logic        tx_busy;
  logic        tx_data_valid;
  logic [15:0] tx_data;
  logic [2:0]  fifo_count;
  logic        stall_err;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
    .GAP_CYCLES(GAP), .BUSY_WAIT(BWAIT), .STALL_LIMIT(SLIM)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .flush(flush), .tx_busy(tx_busy),
    .tx_data_valid(tx_data_valid), .tx_data(tx_data),
    .fifo_count(fifo_count), .stall_err(stall_err)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [15:0] m_q[$];
  int          m_rr;
  int          m_cnt[NUM_REQ];
  logic        m_err;
  logic [15:0] launch_q[$];
  int          launch_cyc[$];
  int          launch_fall[$];
  logic [2:0]  acc_mask;
  int          fall_cyc;
  logic        have_fall, prev_busy;
  logic        uart_auto;
  int          busy_delay, busy_left;

  // One clock: score the cycle at negedge, then step past the edge and run the UART model.
  task automatic advance();
    logic [2:0] exp_ready;
    int g, idx;
    @(negedge clk);
    acc_mask = '0;
    if (!reset_n) begin
      m_q.delete();
      m_rr = 0;
      m_err = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
      have_fall = 1'b0;
      prev_busy = 1'b0;
    end else begin
      exp_ready = '0;
      g = -1;
      if (m_q.size() < DEPTH && !flush) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (m_rr + k) % NUM_REQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++;
        $display("FAIL ready_arb cycle=%0d got=%b exp=%b", cyc, req_ready, exp_ready);
      end
      checks++;
      if (fifo_count !== 3'(m_q.size())) begin
        errors++;
        $display("FAIL fifo_count cycle=%0d got=%0d exp=%0d", cyc, fifo_count, m_q.size());
      end
      checks++;
      if (stall_err !== m_err) begin
        errors++;
        $display("FAIL stall_err cycle=%0d got=%b exp=%b", cyc, stall_err, m_err);
      end
      if (tx_data_valid) begin
        checks++;
        if (m_q.size() == 0) begin
          errors++;
          $display("FAIL launch_unexpected cycle=%0d got=%h exp=none", cyc, tx_data);
        end else begin
          if (tx_data !== m_q[0]) begin
            errors++;
            $display("FAIL launch_data cycle=%0d got=%h exp=%h", cyc, tx_data, m_q[0]);
          end
          void'(m_q.pop_front());
        end
        launch_q.push_back(tx_data);
        launch_cyc.push_back(cyc);
        launch_fall.push_back(have_fall ? fall_cyc : -1);
        have_fall = 1'b0;
      end
      if (flush) m_q.delete();
      if (g >= 0) begin
        m_q.push_back(req_data[g*DW +: DW]);
        acc_mask[g] = 1'b1;
        m_rr = (g + 1) % NUM_REQ;
      end
      if (flush) begin
        m_err = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_valid[i] && !exp_ready[i]) begin
            if (m_cnt[i] < SLIM) m_cnt[i]++;
            if (m_cnt[i] == SLIM) m_err = 1'b1;
          end else begin
            m_cnt[i] = 0;
          end
        end
      end
      if (prev_busy && !tx_busy) begin
        fall_cyc = cyc;
        have_fall = 1'b1;
      end
      prev_busy = tx_busy;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (uart_auto) begin
      if (tx_data_valid) begin
        busy_delay = int'($urandom_range(3, 1));
      end else if (busy_delay > 0) begin
        busy_delay--;
        if (busy_delay == 0) begin
          tx_busy = 1'b1;
          busy_left = int'($urandom_range(20, 4));
        end
      end else if (tx_busy) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
    end
  endtask

  task automatic push(input int idx, input logic [15:0] d, output bit ok);
    ok = 1'b0;
    req_valid[idx] = 1'b1;
    req_data[idx*DW +: DW] = d;
    for (int t = 0; t < 50; t++) begin
      advance();
      if (acc_mask[idx]) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_launches(input int n, input int budget, output bit ok);
    int t = 0;
    while (launch_q.size() < n && t < budget) begin
      advance();
      t++;
    end
    ok = (launch_q.size() >= n);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    flush = 1'b0;
    tx_busy = 1'b0;
    uart_auto = 1'b0;
    busy_delay = 0;
    repeat (3) advance();
    #1;
    checks++; if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", tx_data_valid); end
    checks++; if (tx_data !== 16'h0) begin errors++; $display("FAIL reset_data got=%h exp=0000", tx_data); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_err); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    reset_n = 1'b1;
    repeat (2) advance();
  endtask

  task automatic test_round_robin();
    int base, c0;
    bit ok;
    logic [15:0] exp_d [3];
    exp_d[0] = 16'hA000; exp_d[1] = 16'hB000; exp_d[2] = 16'hC000;
    uart_auto = 1'b1;
    busy_delay = 0;
    base = launch_q.size();
    req_data = {16'hC000, 16'hB000, 16'hA000};
    req_valid = 3'b111;
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (req_ready !== 3'(1 << k)) begin
        errors++;
        $display("FAIL rr_grant step=%0d got=%b exp=%b", k, req_ready, 3'(1 << k));
      end
      advance();
      req_valid[k] = 1'b0;
    end
    wait_launches(base + 3, 400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rr_timeout got=%0d exp=%0d launches", launch_q.size() - base, 3);
    end else begin
      checks++;
      if (launch_cyc[base] !== c0 + 2) begin
        errors++;
        $display("FAIL rr_latency got=%0d exp=%0d", launch_cyc[base], c0 + 2);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (launch_q[base+k] !== exp_d[k]) begin
          errors++;
          $display("FAIL rr_order idx=%0d got=%h exp=%h", k, launch_q[base+k], exp_d[k]);
        end
      end
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (launch_fall[base+k] < 0 || launch_cyc[base+k] - launch_fall[base+k] < GAP ||
            launch_cyc[base+k] - launch_fall[base+k] > GAP + 4) begin
          errors++;
          $display("FAIL rr_gap idx=%0d got=%0d exp=%0d..%0d", k,
                   launch_cyc[base+k] - launch_fall[base+k], GAP, GAP + 4);
        end
      end
    end
    repeat (70) advance();
    uart_auto = 1'b0;
    tx_busy = 1'b0;
  endtask

  task automatic test_single();
    int base, c0;
    bit ok;
    base = launch_q.size();
    req_valid = 3'b010;
    req_data[31:16] = 16'h1234;
    c0 = cyc;
    #1;
    checks++;
    if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready got=%b exp=010", req_ready); end
    advance();
    req_valid = '0;
    wait_launches(base + 1, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_timeout got=0 exp=1 launches");
    end else begin
      checks++;
      if (launch_q[base] !== 16'h1234) begin errors++; $display("FAIL single_data got=%h exp=1234", launch_q[base]); end
      checks++;
      if (launch_cyc[base] !== c0 + 2) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", launch_cyc[base], c0 + 2); end
    end
    advance();
    #1;
    checks++;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_drain got=%0d exp=0", fifo_count); end
    repeat (60) advance();
  endtask

  task automatic test_full_fifo();
    int base, acc, rel;
    bit ok;
    base = launch_q.size();
    tx_busy = 1'b1;
    acc = 0;
    req_valid = 3'b100;
    req_data[47:32] = 16'hD000;
    for (int t = 0; t < 8; t++) begin
      advance();
      if (acc_mask[2]) begin
        acc++;
        req_data[47:32] = 16'hD000 + 16'(acc);
      end
    end
    #1;
    checks++; if (acc !== 4) begin errors++; $display("FAIL full_accepted got=%0d exp=4", acc); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", fifo_count); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL full_ready got=%b exp=000", req_ready); end
    repeat (SLIM) advance();
    #1;
    checks++; if (stall_err !== 1'b1) begin errors++; $display("FAIL full_stall got=%b exp=1", stall_err); end
    req_valid = '0;
    tx_busy = 1'b0;
    rel = cyc;
    wait_launches(base + 4, 400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_drain_timeout got=%0d exp=4 launches", launch_q.size() - base);
    end else begin
      checks++;
      if (launch_cyc[base] - rel < 1 || launch_cyc[base] - rel > 3) begin
        errors++;
        $display("FAIL full_first_launch got=%0d exp=1..3", launch_cyc[base] - rel);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (launch_q[base+k] !== 16'hD000 + 16'(k)) begin
          errors++;
          $display("FAIL full_order idx=%0d got=%h exp=%h", k, launch_q[base+k], 16'hD000 + 16'(k));
        end
      end
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (launch_cyc[base+k] - launch_cyc[base+k-1] < BWAIT + GAP ||
            launch_cyc[base+k] - launch_cyc[base+k-1] > BWAIT + GAP + 4) begin
          errors++;
          $display("FAIL busy_timeout_gap idx=%0d got=%0d exp=%0d..%0d", k,
                   launch_cyc[base+k] - launch_cyc[base+k-1], BWAIT + GAP, BWAIT + GAP + 4);
        end
      end
    end
    repeat (60) advance();
  endtask

  task automatic test_flush();
    int base;
    bit ok;
    base = launch_q.size();
    for (int k = 0; k < 4; k++) begin
      push(0, 16'hE000 + 16'(k), ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL flush_push idx=%0d got=blocked exp=accepted", k); end
    end
    tx_busy = 1'b1;
    advance();
    #1;
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got=%0d exp=3", fifo_count); end
    checks++; if (stall_err !== 1'b1) begin errors++; $display("FAIL flush_pre_stall got=%b exp=1", stall_err); end
    flush = 1'b1;
    req_valid = 3'b010;
    req_data[31:16] = 16'hEEEE;
    #1;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL flush_ready got=%b exp=000", req_ready); end
    advance();
    flush = 1'b0;
    req_valid = '0;
    #1;
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", fifo_count); end
    checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", stall_err); end
    repeat (5) advance();
    tx_busy = 1'b0;
    repeat (80) advance();
    checks++;
    if (launch_q.size() !== base + 1) begin
      errors++;
      $display("FAIL flush_no_launch got=%0d exp=1 launches", launch_q.size() - base);
    end
  endtask

  task automatic test_async_reset();
    int base, c0;
    bit ok;
    push(0, 16'h5A5A, ok);
    push(1, 16'h6B6B, ok);
    for (int t = 0; t < 10 && !tx_data_valid; t++) advance();
    checks++;
    if (tx_data_valid !== 1'b1) begin errors++; $display("FAIL areset_setup got=%b exp=1", tx_data_valid); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b exp=0", tx_data_valid); end
    checks++; if (tx_data !== 16'h0) begin errors++; $display("FAIL areset_data got=%h exp=0000", tx_data); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL areset_count got=%0d exp=0", fifo_count); end
    repeat (2) advance();
    reset_n = 1'b1;
    advance();
    base = launch_q.size();
    req_valid = 3'b100;
    req_data[47:32] = 16'h7C7C;
    c0 = cyc;
    advance();
    req_valid = '0;
    wait_launches(base + 1, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL areset_resume_timeout got=0 exp=1 launches");
    end else begin
      checks++;
      if (launch_q[base] !== 16'h7C7C || launch_cyc[base] !== c0 + 2) begin
        errors++;
        $display("FAIL areset_resume got=%h@%0d exp=7c7c@%0d", launch_q[base], launch_cyc[base], c0 + 2);
      end
    end
    repeat (60) advance();
  endtask

  task automatic test_random();
    int base, t;
    base = launch_q.size();
    uart_auto = 1'b1;
    busy_delay = 0;
    for (int c = 0; c < 700; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || acc_mask[i]) begin
          if ($urandom_range(3, 0) == 0) begin
            req_valid[i] = 1'b1;
            req_data[i*DW +: DW] = 16'($urandom);
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      advance();
    end
    req_valid = '0;
    t = 0;
    while ((m_q.size() != 0 || tx_busy) && t < 2000) begin
      advance();
      t++;
    end
    repeat (50) advance();
    checks++;
    if (m_q.size() != 0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL random_drain got=%0d exp=0 left", fifo_count);
    end
    checks++;
    if (launch_q.size() - base < 5) begin
      errors++;
      $display("FAIL random_progress got=%0d exp>=5 launches", launch_q.size() - base);
    end
    uart_auto = 1'b0;
    tx_busy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_full_fifo();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single UART TX channel between several packet sources: setup/handshake packets, move packets, and control packets such as resign, draw offer and heartbeat.
- Each source gets a valid/ready handshake. Accepted 16-bit packets are buffered in a small FIFO.
- Packets are launched one at a time as single-cycle data_valid pulses into the UART. A launch happens only after the UART reports idle and an inter-packet gap has elapsed.
- Sits between the game-play logic and the UART instance, replacing direct data_valid/data_in_tx drives.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 = setup, 1 = move, 2 = control.
- DATA_WIDTH, 16, packet width (matches the UART frame).
- FIFO_DEPTH, 4, buffered packets; must be a power of 2, ≥2.
- GAP_CYCLES, 32, idle clocks enforced after tx_busy falls before the next launch.
- BUSY_WAIT, 8, clocks to wait for tx_busy to rise after a launch before giving up.
- STALL_LIMIT, 1024, consecutive blocked cycles on any requester that set stall_err.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester packet valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed packets; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  combinational grant; a transfer occurs when req_valid[i] && req_ready[i].
- flush  in  1  synchronous clear of buffered packets and sticky error.
- tx_busy  in  1  UART transmitter busy.
- tx_data_valid  out  1  single-cycle launch pulse to UART data_valid.
- tx_data  out  DATA_WIDTH  packet to UART data_in_tx; valid while tx_data_valid = 1.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  packets currently buffered.
- stall_err  out  1  sticky: some requester was blocked STALL_LIMIT consecutive cycles.

Behaviour:
- Reset values: FIFO empty, fifo_count = 0, FSM = IDLE, tx_data_valid = 0, tx_data = 0, stall_err = 0, rr_ptr = 0, all stall counters = 0.
- Arbitration:
  - At most one grant per cycle, and only when fifo_count < FIFO_DEPTH and flush = 0.
  - Round-robin: search starts at rr_ptr and wraps modulo NUM_REQ. The first i with req_valid[i] = 1 gets req_ready[i] = 1; all other req_ready bits are 0.
  - After a transfer from i, rr_ptr <= (i+1) mod NUM_REQ. rr_ptr is unchanged when no transfer occurs.
  - When full, no ready is asserted, even if a pop happens the same cycle.
- FIFO:
  - Write on transfer, pop on launch. Simultaneous write and pop leaves fifo_count unchanged.
  - Read/write pointers wrap at FIFO_DEPTH.
- Launch FSM:
  - IDLE: if fifo_count > 0 and tx_busy = 0, go to LAUNCH.
  - LAUNCH (1 cycle): tx_data_valid = 1 and tx_data = FIFO head (both registered); pop head; go to WAIT_BUSY.
  - WAIT_BUSY: go to WAIT_DONE when tx_busy = 1. If tx_busy stays 0 for BUSY_WAIT cycles, go to GAP anyway.
  - WAIT_DONE: go to GAP when tx_busy = 0.
  - GAP: count GAP_CYCLES clocks, then go to IDLE.
  - tx_data holds its last value outside LAUNCH; tx_data_valid = 0 in every other state.
- Latency: with the FSM in IDLE, an empty FIFO and tx_busy = 0, a transfer in cycle n produces tx_data_valid in cycle n+2.
- Ordering: packets are launched in acceptance order; there is no reordering inside the FIFO.
- flush:
  - Empties the FIFO (fifo_count = 0 next cycle) and clears stall_err and all stall counters.
  - Blocks grants during the flush cycle.
  - Does not abort the FSM: a packet already launched completes through WAIT_DONE/GAP. A LAUNCH coinciding with flush still emits its pulse.
- Stall detection:
  - Per requester, the counter increments while req_valid[i] && !req_ready[i], and resets on a transfer or when req_valid[i] = 0.
  - Reaching STALL_LIMIT sets stall_err. stall_err is cleared only by reset or flush.
  - Counters saturate at STALL_LIMIT.
- Reset mid-operation: all state returns immediately to reset values and tx_data_valid drops asynchronously. Buffered packets are lost.
- tx_busy high while in IDLE: no launch until it falls. The gap is not applied to busy periods the scheduler did not cause.

Test Plan:
- Single packet: req_valid[1] = 1 with 0x1234 for one cycle (idle, empty) → req_ready[1] = 1 that cycle; tx_data_valid = 1 with tx_data = 0x1234 two cycles later; fifo_count back to 0.
- Round-robin: all three valid with 0xA000/0xB000/0xC000 and held → grants in order 0, 1, 2 on consecutive cycles; launch order A000, B000, C000, each separated by tx_busy high time + GAP_CYCLES.
- Full FIFO: tx_busy held 1 and 5 packets offered by requester 2 → 4 accepted, fifo_count = 4, req_ready[2] = 0 for the 5th; after STALL_LIMIT blocked cycles stall_err = 1; releasing tx_busy drains 4 packets in order.
- BUSY_WAIT timeout: tx_busy never asserts after a launch → FSM reaches GAP after 8 cycles; next packet launches after 32 more cycles.
- flush: FIFO holds 3, one packet in WAIT_DONE, pulse flush → fifo_count = 0 and stall_err = 0 next cycle; in-flight packet finishes; no further tx_data_valid.
- Async reset: assert reset_n = 0 during LAUNCH → tx_data_valid = 0 immediately and all outputs take reset values; normal operation resumes after release.
